serial_sub8: RTL and testbench

Bit-serial two's-complement subtractor: computes `d = a - b - bi` one bit per clock, LSB first, using a single full-adder cell with a registered borrow. It sits beside the 8-bit ripple-carry adder in the arithmetic lab set as its sequential, subtracting counterpart. It trades W cycles of latency for one adder cell and provides a start/busy/done handshake for a controlling FSM or bench.

---
 rtl/serial_sub_pkg.sv | 5 +
 rtl/serial_fa.sv | 11 +
 rtl/serial_sub8.sv | 81 ++++++++
 tb/tb_serial_sub8.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SUB_W_DEF = 8;
endpackage

// File: rtl/serial_fa.sv
// serial_fa: 1-bit full adder cell
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial d = a - b - bi, LSB first via one full adder; ov output with SERIAL_SUB_OVF_EN
module serial_sub8
  import serial_sub_pkg::*;
#(
  parameter int W = SUB_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo,
  output logic         busy,
`ifdef SERIAL_SUB_OVF_EN
  output logic         done,
  output logic         ov
`else
  output logic         done
`endif
);
  localparam int CW = $clog2(W);
  state_t state, state_nx;
  logic [W-1:0] ra, rb;
  logic [W-2:0] res;
  logic [CW-1:0] cnt;
  logic c, s, co, last;
`ifdef SERIAL_SUB_OVF_EN
  logic am, bm;
`endif
  serial_fa u_fa (.a(ra[0]), .b(rb[0]), .ci(c), .s(s), .co(co));
  assign last = cnt == CW'(W - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      res <= '0;
      cnt <= '0;
      c   <= 1'b0;
      d   <= '0;
      bo  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am  <= 1'b0;
      bm  <= 1'b0;
      ov  <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      ra  <= a;
      rb  <= ~b;
      c   <= ~bi;
      cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
      am  <= a[W-1];
      bm  <= b[W-1];
`endif
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      c   <= co;
      cnt <= cnt + 1'b1;
      res <= (W-1)'({s, res} >> 1);
      if (last) begin
        d  <= {s, res};
        bo <= ~co;
`ifdef SERIAL_SUB_OVF_EN
        ov <= (am != bm) && (s != am);
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: randomized scoreboard bench for serial_sub8 (ov checked with SERIAL_SUB_OVF_EN)
module tb_serial_sub8;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           acc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bi = 1'b0;
  logic [W-1:0] a = '0, b = '0, d;
  logic bo, busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic ov;
`endif
  exp_t q[$];
  int cmp = 0, err = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_sub8 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bi(bi),
    .d(d), .bo(bo), .busy(busy),
`ifdef SERIAL_SUB_OVF_EN
    .done(done), .ov(ov)
`else
    .done(done)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input int av, input int bv, input int biv, input int acc);
    exp_t e;
    int diff, sa, sb, sd, half;
    half = 1 << (W - 1);
    diff = av - bv - biv;
    e.d = W'(diff);
    e.bo = diff < 0;
    sa = av >= half ? av - (1 << W) : av;
    sb = bv >= half ? bv - (1 << W) : bv;
    sd = sa - sb - biv;
    e.ov = sd < -half || sd >= half;
    e.acc = acc;
    return e;
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        cmp++;
        err++;
        $display("FAIL unexpected_done: got d=%0h bo=%0b expected no done", d, bo);
      end else begin
        e = q.pop_front();
        chk("d", d, e.d);
        chk("bo", bo, e.bo);
`ifdef SERIAL_SUB_OVF_EN
        chk("ov", ov, e.ov);
`endif
        chk("latency", cyc - e.acc, W);
        chk("busy_in_done", busy, 1);
      end
    end
  end
  task automatic issue(input int av, input int bv, input int biv);
    int n = 0;
    @(negedge clk);
    while (busy && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", busy, 0);
    a = W'(av);
    b = W'(bv);
    bi = biv[0];
    start = 1'b1;
    q.push_back(model(av, bv, biv, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_done_early", done, 0);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
    q.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_d", d, 0);
    chk("rst_bo", bo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ov", ov, 0);
`endif
    rst_n = 1'b1;
    issue(100, 0, 0);
    drain();
    issue(0, 1, 0);
    issue(8'h80, 1, 0);
    issue(5, 5, 1);
    drain();
    issue(20, 3, 0);
    chk("d_hold", d, model(5, 5, 1, 0).d);
    a = 1;
    b = 2;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    drain();
    issue(50, 10, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    void'(q.pop_back());
    chk("abort_busy", busy, 0);
    chk("abort_d", d, 0);
    chk("abort_bo", bo, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    repeat (2 * W) @(negedge clk);
    issue(9, 4, 0);
    drain();
    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, 1)));
      if (i % 4 == 3) drain();
    end
    drain();
    for (int i = 0; i < 6 * (W + 2); i++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      bi = 1'($urandom);
      start = 1'b1;
      if (!busy) q.push_back(model(int'(a), int'(b), int'(bi), cyc + 1));
    end
    @(negedge clk);
    start = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
